// File: rtl/btn_debouncer.sv
// Push-button debouncer: two-flop synchronizer followed by a four-state FSM that
// accepts a new level only after STABLE_TICKS consecutive stable sample ticks.
module btn_debouncer #(
  parameter int STABLE_TICKS = 10,
  parameter int CNT_W        = $clog2(STABLE_TICKS + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       btn_in,
  output logic       db_out,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [1:0] db_state
);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_TICKS - 1);

  logic             sync1;
  logic             btn_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1         <= 1'b0;
      btn_s         <= 1'b0;
      state         <= S_LOW;
      cnt           <= '0;
      db_out        <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= btn_in;
      btn_s         <= sync1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        S_LOW: begin
          if (btn_s) begin
            state <= S_WAIT_HIGH;
            cnt   <= '0;
          end
        end
        // A level change back aborts immediately, even without a tick.
        S_WAIT_HIGH: begin
          if (!btn_s) begin
            state <= S_LOW;
            cnt   <= '0;
          end else if (tick_in) begin
            if (cnt == LAST_CNT) begin
              state       <= S_HIGH;
              db_out      <= 1'b1;
              press_pulse <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (!btn_s) begin
            state <= S_WAIT_LOW;
            cnt   <= '0;
          end
        end
        S_WAIT_LOW: begin
          if (btn_s) begin
            state <= S_HIGH;
            cnt   <= '0;
          end else if (tick_in) begin
            if (cnt == LAST_CNT) begin
              state         <= S_LOW;
              db_out        <= 1'b0;
              release_pulse <= 1'b1;
              cnt           <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign db_state = state;

endmodule
